// File: rtl/mc_mem_responder_pkg.sv
// Shared definitions for the memory responder: default geometry, the
// read-latency ceiling, counter width and a saturating-increment helper.
package mc_mem_responder_pkg;

   localparam int DEF_DATA_TYPE    = 32;
   localparam int DEF_ADDR_TYPE    = 32;
   localparam int DEF_MEM_DEPTH    = 1024;
   localparam int MAX_READ_LATENCY = 4;
   localparam int CNT_W            = 16;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

   // Increment by one when enabled, sticking at the all-ones value.
   function automatic cnt_t sat_inc(input cnt_t cnt, input logic en);
      cnt_t res;
      if (en && (cnt != CNT_MAX)) begin
         res = cnt + cnt_t'(1'b1);
      end else begin
         res = cnt;
      end
      return res;
   endfunction

endpackage

// File: rtl/mc_mem_responder_if.sv
// Load/store bus between a requester (master) and the memory responder (slave).
interface mc_mem_responder_if #(
   parameter int DATA_W = mc_mem_responder_pkg::DEF_DATA_TYPE,
   parameter int ADDR_W = mc_mem_responder_pkg::DEF_ADDR_TYPE
);
   import mc_mem_responder_pkg::*;

   logic              loadEn;
   logic [ADDR_W-1:0] loadAddr;
   logic [DATA_W-1:0] loadData;
   logic              loadValid;
   logic              storeEn;
   logic [ADDR_W-1:0] storeAddr;
   logic [DATA_W-1:0] storeData;
   logic [CNT_W-1:0]  readCount;
   logic [CNT_W-1:0]  writeCount;
   logic              addrErr;

   modport master (
      output loadEn, loadAddr, storeEn, storeAddr, storeData,
      input  loadData, loadValid, readCount, writeCount, addrErr
   );

   modport slave (
      input  loadEn, loadAddr, storeEn, storeAddr, storeData,
      output loadData, loadValid, readCount, writeCount, addrErr
   );

endinterface

// File: rtl/mc_mem_responder_read_pipe.sv
// mc_read_pipe: extra read-latency stages behind the RAM output register.
// Valid shifts every cycle; data only advances with a valid beat, so the
// last stage keeps the most recently returned word while valid is low.
module mc_read_pipe #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_s;
      assign unused_s  = clk ^ rst;
      assign out_valid = in_valid;
      assign out_data  = in_data;
   end else begin : g_shift
      logic [DEPTH-1:0]  vld_q;
      logic [DEPTH-1:0]  vld_d;
      logic [DATA_W-1:0] dat_q [DEPTH];
      logic [DATA_W-1:0] dat_d [DEPTH];
      logic [DEPTH:0]    chain_v;
      logic [DATA_W-1:0] chain_d [DEPTH+1];

      assign chain_v[0] = in_valid;
      assign chain_d[0] = in_data;
      for (genvar i = 0; i < DEPTH; i++) begin : g_chain
         assign chain_v[i+1] = vld_q[i];
         assign chain_d[i+1] = dat_q[i];
      end

      // Next stage contents: valid always shifts, data moves only with valid.
      always_comb begin
         vld_d = {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            vld_d[i] = chain_v[i];
            if (chain_v[i]) begin
               dat_d[i] = chain_d[i];
            end else begin
               dat_d[i] = dat_q[i];
            end
         end
      end

      // Stage registers; reset flushes anything in flight.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
               dat_q[i] <= {DATA_W{1'b0}};
            end
         end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
               dat_q[i] <= dat_d[i];
            end
         end
      end

      assign out_valid = chain_v[DEPTH];
      assign out_data  = chain_d[DEPTH];
   end

endmodule

// File: rtl/mc_mem_responder.sv
// Single-port-pair memory responder: one read and one write per cycle,
// read-first on collisions, out-of-range detection on the high address bits,
// saturating request counters and a configurable read latency.
module mc_mem_responder import mc_mem_responder_pkg::*; #(
   parameter int DATA_TYPE    = DEF_DATA_TYPE,
   parameter int ADDR_TYPE    = DEF_ADDR_TYPE,
   parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   mc_mem_responder_if.slave       bus
);

   localparam int IDX_W = $clog2(MEM_DEPTH);

   // Any set bit above the word index makes the address out of range.
   function automatic logic out_of_range(input logic [ADDR_TYPE-1:0] addr);
      return (addr >> IDX_W) != {ADDR_TYPE{1'b0}};
   endfunction

   logic [DATA_TYPE-1:0] mem_q [MEM_DEPTH];

   logic                 ld_oor_s;
   logic                 st_oor_s;
   logic [IDX_W-1:0]     ld_idx_s;
   logic [IDX_W-1:0]     st_idx_s;
   logic                 mem_we_s;

   logic                 rd_valid_q, rd_valid_d;
   logic [DATA_TYPE-1:0] rd_data_q,  rd_data_d;
   cnt_t                 rd_cnt_q,   rd_cnt_d;
   cnt_t                 wr_cnt_q,   wr_cnt_d;
   logic                 err_q,      err_d;

   assign ld_oor_s = out_of_range(bus.loadAddr);
   assign st_oor_s = out_of_range(bus.storeAddr);
   assign ld_idx_s = bus.loadAddr[IDX_W-1:0];
   assign st_idx_s = bus.storeAddr[IDX_W-1:0];
   // Writes are held off while in reset so nothing lands before the first accepted edge.
   assign mem_we_s = bus.storeEn & ~st_oor_s & rst;

   // Next-state for the RAM output register, counters and sticky error.
   always_comb begin
      rd_valid_d = bus.loadEn;
      rd_data_d  = rd_data_q;
      if (bus.loadEn) begin
         if (ld_oor_s) begin
            rd_data_d = {DATA_TYPE{1'b0}};
         end else begin
            rd_data_d = mem_q[ld_idx_s];
         end
      end else begin
         rd_data_d = rd_data_q;
      end
      rd_cnt_d = sat_inc(rd_cnt_q, bus.loadEn);
      wr_cnt_d = sat_inc(wr_cnt_q, bus.storeEn);
      err_d    = err_q | (bus.loadEn & ld_oor_s) | (bus.storeEn & st_oor_s);
   end

   // Storage array: no reset so contents survive it; the read above samples
   // the pre-write value, giving read-first behaviour on collisions.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[st_idx_s] <= bus.storeData;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= {DATA_TYPE{1'b0}};
         rd_cnt_q   <= {CNT_W{1'b0}};
         wr_cnt_q   <= {CNT_W{1'b0}};
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         err_q      <= err_d;
      end
   end

   mc_read_pipe #(
      .DATA_W (DATA_TYPE),
      .DEPTH  (READ_LATENCY - 1)
   ) u_read_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_valid_q),
      .in_data   (rd_data_q),
      .out_valid (bus.loadValid),
      .out_data  (bus.loadData)
   );

   assign bus.readCount  = rd_cnt_q;
   assign bus.writeCount = wr_cnt_q;
   assign bus.addrErr    = err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench: three responders (read latency 1, 2, 3) driven with the same
// stimulus and compared every cycle against a cycle-indexed reference model,
// plus a vector table and directed multi-cycle sequences.
module tb_mc_mem_responder;

   localparam int NK = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        ld_en, st_en;
   logic [31:0] ld_addr, st_addr, st_data;

   mc_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) if_l1 ();
   mc_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) if_l2 ();
   mc_mem_responder_if #(.DATA_W(32), .ADDR_W(32)) if_l3 ();

   assign if_l1.loadEn = ld_en;  assign if_l1.loadAddr = ld_addr;
   assign if_l1.storeEn = st_en; assign if_l1.storeAddr = st_addr; assign if_l1.storeData = st_data;
   assign if_l2.loadEn = ld_en;  assign if_l2.loadAddr = ld_addr;
   assign if_l2.storeEn = st_en; assign if_l2.storeAddr = st_addr; assign if_l2.storeData = st_data;
   assign if_l3.loadEn = ld_en;  assign if_l3.loadAddr = ld_addr;
   assign if_l3.storeEn = st_en; assign if_l3.storeAddr = st_addr; assign if_l3.storeData = st_data;

   mc_mem_responder #(.READ_LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(if_l1));
   mc_mem_responder #(.READ_LATENCY(2)) dut_l2 (.clk(clk), .rst(rst), .bus(if_l2));
   mc_mem_responder #(.READ_LATENCY(3)) dut_l3 (.clk(clk), .rst(rst), .bus(if_l3));

   logic        dv  [NK];
   logic [31:0] dd  [NK];
   logic [15:0] drc [NK];
   logic [15:0] dwc [NK];
   logic        de  [NK];

   assign dv[0] = if_l1.loadValid; assign dd[0] = if_l1.loadData; assign drc[0] = if_l1.readCount;
   assign dwc[0] = if_l1.writeCount; assign de[0] = if_l1.addrErr;
   assign dv[1] = if_l2.loadValid; assign dd[1] = if_l2.loadData; assign drc[1] = if_l2.readCount;
   assign dwc[1] = if_l2.writeCount; assign de[1] = if_l2.addrErr;
   assign dv[2] = if_l3.loadValid; assign dd[2] = if_l3.loadData; assign drc[2] = if_l3.readCount;
   assign dwc[2] = if_l3.writeCount; assign de[2] = if_l3.addrErr;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: word store for addresses 0..31, per-cycle read results.
   logic [31:0] m_mem [32];
   logic        rv [8];
   logic [31:0] rd [8];
   logic [15:0] m_rc, m_wc;
   logic        m_err;
   logic        e_v [NK];
   logic [31:0] e_d [NK];
   int          cyc = 0;

   typedef struct {
      logic        le;
      logic [31:0] la;
      logic        se;
      logic [31:0] sa;
      logic [31:0] sd;
      logic        ev;
      logic [31:0] ed;
      logic        ee;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic le, input logic [31:0] la, input logic se,
                        input logic [31:0] sa, input logic [31:0] sd);
      ld_en = le; ld_addr = la; st_en = se; st_addr = sa; st_data = sd;
   endtask

   task automatic update_expect();
      for (int k = 0; k < NK; k++) begin
         int slot;
         slot = (cyc - (k + 1)) & 7;
         e_v[k] = rv[slot];
         if (rv[slot]) e_d[k] = rd[slot];
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < NK; k++) begin
         check($sformatf("L%0d loadValid", k + 1), {31'd0, dv[k]}, {31'd0, e_v[k]});
         check($sformatf("L%0d loadData", k + 1), dd[k], e_d[k]);
         check($sformatf("L%0d readCount", k + 1), {16'd0, drc[k]}, {16'd0, m_rc});
         check($sformatf("L%0d writeCount", k + 1), {16'd0, dwc[k]}, {16'd0, m_wc});
         check($sformatf("L%0d addrErr", k + 1), {31'd0, de[k]}, {31'd0, m_err});
      end
   endtask

   // One clock: model consumes the request at the edge, outputs checked at negedge.
   task automatic step(input bit do_chk);
      @(posedge clk);
      if (rst == 1'b0) begin
         rv[cyc & 7] = 1'b0;
      end else begin
         if (ld_en) begin
            rv[cyc & 7] = 1'b1;
            if (ld_addr >= 32'd1024) begin
               rd[cyc & 7] = 32'd0;
               m_err = 1'b1;
            end else begin
               rd[cyc & 7] = m_mem[ld_addr[4:0]];
            end
            if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
         end else begin
            rv[cyc & 7] = 1'b0;
         end
         if (st_en) begin
            if (st_addr >= 32'd1024) m_err = 1'b1;
            else m_mem[st_addr[4:0]] = st_data;
            if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
         end
      end
      cyc++;
      update_expect();
      @(negedge clk);
      if (do_chk) check_all();
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) rv[i] = 1'b0;
      for (int k = 0; k < NK; k++) begin
         e_v[k] = 1'b0;
         e_d[k] = 32'd0;
      end
      m_rc = 16'd0; m_wc = 16'd0; m_err = 1'b0;
      #1;
      check_all();
      repeat (n) step(1'b1);
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0:       a = 32'd1024 | ($urandom() & 32'h0000_03FF);
         1:       a = 32'h8000_0000 | ($urandom() & 32'h0000_001F);
         default: a = $urandom_range(0, 31);
      endcase
      return a;
   endfunction

   initial begin
      tbl[0] = '{1'b0, 32'd0,          1'b1, 32'd5,    32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0};
      tbl[1] = '{1'b1, 32'd5,          1'b0, 32'd0,    32'd0,         1'b1, 32'hDEAD_BEEF, 1'b0};
      tbl[2] = '{1'b0, 32'd0,          1'b1, 32'd7,    32'h0000_0011, 1'b0, 32'hDEAD_BEEF, 1'b0};
      tbl[3] = '{1'b1, 32'd7,          1'b1, 32'd7,    32'h0000_0055, 1'b1, 32'h0000_0011, 1'b0};
      tbl[4] = '{1'b1, 32'd7,          1'b0, 32'd0,    32'd0,         1'b1, 32'h0000_0055, 1'b0};
      tbl[5] = '{1'b0, 32'd0,          1'b0, 32'd0,    32'd0,         1'b0, 32'h0000_0055, 1'b0};
      tbl[6] = '{1'b0, 32'd0,          1'b1, 32'd1024, 32'hAAAA_0000, 1'b0, 32'h0000_0055, 1'b1};
      tbl[7] = '{1'b1, 32'd1024,       1'b0, 32'd0,    32'd0,         1'b1, 32'h0000_0000, 1'b1};
      tbl[8] = '{1'b1, 32'd0,          1'b0, 32'd0,    32'd0,         1'b1, 32'hC0DE_0000, 1'b1};
      tbl[9] = '{1'b1, 32'h8000_0005,  1'b0, 32'd0,    32'd0,         1'b1, 32'h0000_0000, 1'b1};

      rst = 1'b1;
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      #2;
      apply_reset(2);

      // Preload the model-tracked window.
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 32'd0, 1'b1, i, 32'hC0DE_0000 + i);
         step(1'b1);
      end

      // Vector table, expectations for the latency-1 instance.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].le, tbl[i].la, tbl[i].se, tbl[i].sa, tbl[i].sd);
         step(1'b1);
         check($sformatf("tbl[%0d] loadValid", i), {31'd0, dv[0]}, {31'd0, tbl[i].ev});
         check($sformatf("tbl[%0d] loadData", i), dd[0], tbl[i].ed);
         check($sformatf("tbl[%0d] addrErr", i), {31'd0, de[0]}, {31'd0, tbl[i].ee});
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(), $urandom());
         step(1'b1);
      end

      // Latency 3: back-to-back reads returned in order, then data holds.
      drive(1'b0, 32'd0, 1'b1, 32'd0, 32'd10); step(1'b1);
      drive(1'b0, 32'd0, 1'b1, 32'd1, 32'd11); step(1'b1);
      drive(1'b0, 32'd0, 1'b1, 32'd2, 32'd12); step(1'b1);
      drive(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);  step(1'b1);
      drive(1'b1, 32'd1, 1'b0, 32'd0, 32'd0);  step(1'b1);
      drive(1'b1, 32'd2, 1'b0, 32'd0, 32'd0);  step(1'b1);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("L3 t+3 valid", {31'd0, dv[2]}, 32'd1); check("L3 t+3 data", dd[2], 32'd10);
      step(1'b1);
      check("L3 t+4 valid", {31'd0, dv[2]}, 32'd1); check("L3 t+4 data", dd[2], 32'd11);
      step(1'b1);
      check("L3 t+5 valid", {31'd0, dv[2]}, 32'd1); check("L3 t+5 data", dd[2], 32'd12);
      step(1'b1);
      check("L3 t+6 valid", {31'd0, dv[2]}, 32'd0); check("L3 t+6 hold", dd[2], 32'd12);

      // Reset one cycle after a read at latency 2: the read must vanish.
      drive(1'b0, 32'd0, 1'b1, 32'd5, 32'h0BAD_F00D); step(1'b1);
      drive(1'b1, 32'd5, 1'b0, 32'd0, 32'd0);         step(1'b1);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      apply_reset(2);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check("L2 post-reset valid", {31'd0, dv[1]}, 32'd0);
         check("L2 post-reset readCount", {16'd0, drc[1]}, 32'd0);
      end
      drive(1'b1, 32'd5, 1'b0, 32'd0, 32'd0); step(1'b1);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0); step(1'b1);
      check("L2 retained valid", {31'd0, dv[1]}, 32'd1);
      check("L2 retained data", dd[1], 32'h0BAD_F00D);

      // Out-of-range write then read after a fresh reset.
      apply_reset(1);
      drive(1'b0, 32'd0, 1'b1, 32'd1024, 32'h1234_5678); step(1'b1);
      drive(1'b1, 32'd1024, 1'b0, 32'd0, 32'd0);        step(1'b1);
      check("oor read valid", {31'd0, dv[0]}, 32'd1);
      check("oor read data", dd[0], 32'd0);
      drive(1'b1, 32'd0, 1'b0, 32'd0, 32'd0); step(1'b1);
      check("oor write dropped", dd[0], 32'd10);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      repeat (3) step(1'b1);
      check("oor addrErr sticky", {31'd0, de[0]}, 32'd1);
      check("oor writeCount", {16'd0, dwc[0]}, 32'd1);
      check("oor readCount", {16'd0, drc[0]}, 32'd2);
      apply_reset(1);
      check("addrErr cleared", {31'd0, de[0]}, 32'd0);

      // Read counter saturation.
      drive(1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
      for (int i = 0; i < 70000; i++) step(1'b0);
      step(1'b1);
      check("readCount saturated", {16'd0, drc[0]}, 32'h0000_FFFF);
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      step(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
